// File: rtl/v810_ifq_if.sv
// Bus bundle for v810_ifq: EU instruction fetch port plus decoder-facing queue port.
// master = fetch queue side, slave = memory unit / decoder / branch unit side.
interface v810_ifq_if;
    logic [31:0] EUIA;
    logic        EUIREQ;
    logic        EUIACK;
    logic [31:0] EUID;
    logic        BR_VALID;
    logic [31:0] BR_TARGET;
    logic [31:0] IQ_D;
    logic [1:0]  IQ_HV;
    logic [31:0] IQ_PC;
    logic [1:0]  IQ_TAKE;

    modport master (
        output EUIA, EUIREQ, IQ_D, IQ_HV, IQ_PC,
        input  EUIACK, EUID, BR_VALID, BR_TARGET, IQ_TAKE
    );

    modport slave (
        input  EUIA, EUIREQ, IQ_D, IQ_HV, IQ_PC,
        output EUIACK, EUID, BR_VALID, BR_TARGET, IQ_TAKE
    );
endinterface

// File: rtl/v810_ifq.sv
// v810_ifq: halfword instruction fetch queue with branch redirect and fetch drop.
// Define IFQ_BYPASS_EN to forward ack data straight to the decoder when the queue is empty.
module v810_ifq #(
    parameter int unsigned DEPTH_HW = 4,
    parameter logic [31:0] RESET_PC = 32'hFFFF_FFF0
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       CE,
    v810_ifq_if.master bus
);
    localparam int unsigned AW = $clog2(DEPTH_HW);
    localparam int unsigned CW = AW + 1;
    // A request may only go out while at least two halfword slots are free.
    localparam logic [CW-1:0] REQ_MAX_CNT = CW'(DEPTH_HW - 2);

    typedef enum logic [1:0] {F_IDLE, F_REQ, F_DROP} fstate_t;

    fstate_t       r_state;
    fstate_t       w_state_nx;
    logic [15:0]   r_mem [DEPTH_HW];
    logic [AW-1:0] r_rptr;
    logic [AW-1:0] r_wptr;
    logic [CW-1:0] r_count;
    logic [31:1]   r_fa;
    logic [31:0]   r_pc;

    logic          w_ack_q;
    logic          w_byp;
    logic [1:0]    w_take;
    logic [1:0]    w_deq;
    logic [1:0]    w_add;
    logic [15:0]   w_h0;
    logic [15:0]   w_h1;
    logic [CW-1:0] w_count_nx;
    logic [AW-1:0] w_rptr1;
    logic [AW-1:0] w_wptr1;

    assign w_rptr1 = r_rptr + 1'b1;
    assign w_wptr1 = r_wptr + 1'b1;

    always_comb begin
        w_take  = bus.BR_VALID ? 2'd0 : bus.IQ_TAKE;
        w_ack_q = (r_state == F_REQ) && bus.EUIACK && !bus.BR_VALID;
        w_h0    = r_fa[1] ? bus.EUID[31:16] : bus.EUID[15:0];
        w_h1    = bus.EUID[31:16];
        w_add   = !w_ack_q ? 2'd0 : (r_fa[1] ? 2'd1 : 2'd2);
        w_byp   = 1'b0;
`ifdef IFQ_BYPASS_EN
        // Forwarded halfwords the decoder takes right away never enter the buffer.
        w_byp = w_ack_q && (r_count == '0);
        if (w_byp) begin
            if (w_take == 2'd1) w_h0 = w_h1;
            w_add = w_add - w_take;
        end
`endif
        w_deq      = w_byp ? 2'd0 : w_take;
        w_count_nx = r_count - CW'(w_deq) + CW'(w_add);
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            F_IDLE: if (!bus.BR_VALID && (r_count <= REQ_MAX_CNT)) w_state_nx = F_REQ;
            F_REQ: begin
                if (bus.BR_VALID)    w_state_nx = bus.EUIACK ? F_REQ : F_DROP;
                else if (bus.EUIACK) w_state_nx = (w_count_nx <= REQ_MAX_CNT) ? F_REQ : F_IDLE;
            end
            F_DROP: if (bus.EUIACK) w_state_nx = F_REQ;
            default: w_state_nx = F_IDLE;
        endcase
    end

    always_comb begin
        bus.EUIREQ = (r_state == F_REQ) || (r_state == F_DROP);
        bus.EUIA   = {r_fa[31:2], 2'b00};
        bus.IQ_PC  = r_pc;
        bus.IQ_D   = {r_mem[w_rptr1], r_mem[r_rptr]};
        bus.IQ_HV  = (r_count >= CW'(2)) ? 2'd2 : r_count[1:0];
`ifdef IFQ_BYPASS_EN
        if (w_ack_q && (r_count == '0)) begin
            bus.IQ_D  = r_fa[1] ? {16'h0000, bus.EUID[31:16]} : bus.EUID;
            bus.IQ_HV = r_fa[1] ? 2'd1 : 2'd2;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (CE) begin
            if (RES) begin
                r_state <= F_IDLE;
                r_count <= '0;
                r_rptr  <= '0;
                r_wptr  <= '0;
                r_fa    <= RESET_PC[31:1];
                r_pc    <= RESET_PC;
            end else begin
                r_state <= w_state_nx;
                if (bus.BR_VALID) begin
                    r_count <= '0;
                    r_rptr  <= '0;
                    r_wptr  <= '0;
                    r_fa    <= bus.BR_TARGET[31:1];
                    r_pc    <= {bus.BR_TARGET[31:1], 1'b0};
                end else begin
                    r_count <= w_count_nx;
                    r_rptr  <= r_rptr + AW'(w_deq);
                    r_wptr  <= r_wptr + AW'(w_add);
                    r_pc    <= r_pc + {29'd0, w_take, 1'b0};
                    // After a misaligned first fetch, continue on the next aligned word.
                    if (w_ack_q) r_fa <= {r_fa[31:2] + 30'd1, 1'b0};
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (CE && !RES && (w_add != 2'd0)) begin
            r_mem[r_wptr] <= w_h0;
            if (w_add == 2'd2) r_mem[w_wptr1] <= w_h1;
        end
    end

    a_take_le_hv: assert property (@(posedge CLK)
        (CE && !RES && !bus.BR_VALID) |-> (bus.IQ_TAKE <= bus.IQ_HV))
        else $fatal(1, "v810_ifq: IQ_TAKE larger than IQ_HV");
endmodule

// File: tb/tb_v810_ifq.sv
// Scoreboard bench for v810_ifq: fetched halfwords are queued with their addresses when
// acked and compared against IQ_D/IQ_PC as the decoder side consumes them.
module tb_v810_ifq;
    localparam logic [31:0] RST_PC = 32'hFFFF_FFF0;

    typedef struct packed {
        logic [31:0] pc;
        logic [15:0] hw;
    } hw_t;

    logic clk = 1'b0;
    logic rst;
    logic ce;
    v810_ifq_if bus ();

    v810_ifq #(.DEPTH_HW(4), .RESET_PC(RST_PC)) dut (
        .CLK(clk), .RES(rst), .CE(ce), .bus(bus)
    );

    always #5 clk = ~clk;

    hw_t         sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_fa;
    logic        m_drop;
    int          req_age;
    int          acks;
    int          ack_mode;     // 0: never, 1: zero-wait, 2: one cycle after EUIREQ
    int          take_pat[$];
    int          tp_i;
    logic        const_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return const_data ? 32'h2222_1111 : {a[15:0] + 16'd2, a[15:0]};
    endfunction

    task automatic step(input logic br = 1'b0, input logic [31:0] tgt = 32'd0,
                        input int ack_ovr = -1);
        logic        ack;
        int          take;
        logic [31:0] wa;
        logic [31:0] w;
        hw_t         e;
        if (ack_ovr >= 0) ack = (ack_ovr != 0);
        else ack = (bus.EUIREQ === 1'b1) && ((ack_mode == 1) || (ack_mode == 2 && req_age >= 1));
        take = 0;
        if (!rst) begin
            chk("iq_hv", {30'd0, bus.IQ_HV}, (sb.size() >= 2) ? 2 : sb.size());
            if (!br && take_pat.size() > 0) begin
                take = take_pat[tp_i % take_pat.size()];
                tp_i++;
                if (take > int'(bus.IQ_HV)) take = int'(bus.IQ_HV);
                if (take > sb.size()) take = sb.size();
            end
        end
        for (int i = 0; i < take; i++) begin
            e = sb.pop_front();
            chk("iq_pc", bus.IQ_PC + 32'(2 * i), e.pc);
            chk("iq_d", {16'd0, (i == 0) ? bus.IQ_D[15:0] : bus.IQ_D[31:16]}, {16'd0, e.hw});
        end
        if (rst) begin
            sb.delete();
            m_fa   = RST_PC;
            m_drop = 1'b0;
        end else if (br) begin
            sb.delete();
            m_fa   = {tgt[31:1], 1'b0};
            m_drop = (bus.EUIREQ === 1'b1) && !ack;
        end else if (ack && m_drop) begin
            m_drop = 1'b0;
        end else if (ack) begin
            wa = {m_fa[31:2], 2'b00};
            chk("euia", bus.EUIA, wa);
            w = word_at(wa);
            if (!m_fa[1]) sb.push_back('{wa, w[15:0]});
            sb.push_back('{wa + 32'd2, w[31:16]});
            m_fa = wa + 32'd4;
            acks++;
        end
        req_age        = ((bus.EUIREQ === 1'b1) && !ack) ? req_age + 1 : 0;
        bus.EUIACK     = ack;
        bus.EUID       = word_at({bus.EUIA[31:2], 2'b00});
        bus.IQ_TAKE    = 2'(take);
        bus.BR_VALID   = br;
        bus.BR_TARGET  = tgt;
        @(posedge clk);
        #1;
        bus.EUIACK   = 1'b0;
        bus.BR_VALID = 1'b0;
        bus.IQ_TAKE  = 2'd0;
    endtask

    task automatic wait_req(input string tag);
        int k = 0;
        while (bus.EUIREQ !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        chk(tag, {31'd0, bus.EUIREQ}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "tb_v810_ifq watchdog");
    end

    initial begin
        int a0;
        bus.EUIACK = 1'b0; bus.EUID = '0; bus.BR_VALID = 1'b0;
        bus.BR_TARGET = '0; bus.IQ_TAKE = 2'd0;
        ce = 1'b1; rst = 1'b1;
        m_fa = RST_PC; m_drop = 1'b0; req_age = 0; acks = 0;
        ack_mode = 0; tp_i = 0; const_data = 1'b1;

        // Reset state
        step(); step();
        chk("rst_euireq", {31'd0, bus.EUIREQ}, 32'd0);
        chk("rst_hv", {30'd0, bus.IQ_HV}, 32'd0);
        chk("rst_pc", bus.IQ_PC, RST_PC);
        rst = 1'b0;

        // Fill with one-cycle-late acks, decoder idle
        ack_mode = 2; take_pat = {0};
        repeat (12) step();
        chk("fill_euireq", {31'd0, bus.EUIREQ}, 32'd0);
        chk("fill_d", bus.IQ_D, 32'h2222_1111);
        chk("fill_hv", {30'd0, bus.IQ_HV}, 32'd2);
        chk("fill_pc", bus.IQ_PC, RST_PC);

        // Streaming: take 2 per cycle, zero-wait acks, address wrap at 2^32
        const_data = 1'b0; ack_mode = 1; take_pat = {2};
        repeat (6) step();
        a0 = acks;
        repeat (10) step();
        chk("no_bubble", 32'(acks - a0), 32'd10);

        // Pointer wrap with uneven consumption
        take_pat = {1, 2, 1}; tp_i = 0;
        repeat (24) step();

        // Redirect while a fetch is outstanding: drop, then misaligned restart
        ack_mode = 0; take_pat = {2};
        wait_req("t4_req");
        take_pat = {0};
        step(1'b1, 32'h0000_1002, 0);
        chk("drop_euireq", {31'd0, bus.EUIREQ}, 32'd1);
        step(1'b0, 32'd0, 1);
        step(1'b0, 32'd0, 1);
        chk("mis_pc", bus.IQ_PC, 32'h0000_1002);
        chk("mis_hv", {30'd0, bus.IQ_HV}, 32'd1);
        chk("mis_d", {16'd0, bus.IQ_D[15:0]}, 32'h0000_1002);

        // Redirect coinciding with an ack
        step(1'b1, 32'h0000_2000, 1);
        chk("brack_hv", {30'd0, bus.IQ_HV}, 32'd0);
        chk("brack_pc", bus.IQ_PC, 32'h0000_2000);
        chk("brack_euia", bus.EUIA, 32'h0000_2000);
        ack_mode = 1; take_pat = {2};
        repeat (8) step();

        // Redirect again while already dropping
        ack_mode = 0;
        wait_req("t5_req");
        take_pat = {0};
        step(1'b1, 32'h0000_3000, 0);
        step(1'b1, 32'h0000_3006, 0);
        chk("redrop_euia", bus.EUIA, 32'h0000_3004);
        step(1'b0, 32'd0, 1);
        step(1'b0, 32'd0, 1);
        chk("redrop_pc", bus.IQ_PC, 32'h0000_3006);
        take_pat = {1};
        repeat (3) step();

        // Reset in the middle of a fetch, late ack ignored
        take_pat = {2};
        wait_req("t6_req");
        rst = 1'b1;
        step(1'b0, 32'd0, 0);
        chk("mrst_euireq", {31'd0, bus.EUIREQ}, 32'd0);
        chk("mrst_hv", {30'd0, bus.IQ_HV}, 32'd0);
        step(1'b0, 32'd0, 1);
        chk("mrst_euireq2", {31'd0, bus.EUIREQ}, 32'd0);
        chk("mrst_pc", bus.IQ_PC, RST_PC);
        rst = 1'b0;
        ack_mode = 1; take_pat = {0};
        repeat (6) step();
        chk("restart_pc", bus.IQ_PC, RST_PC);
        chk("restart_hv", {30'd0, bus.IQ_HV}, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/v810_ifq.md
Name: v810_ifq

Overview:
Instruction fetch queue upstream of the memory access unit. Drives the unit's EU instruction bus (EUIA/EUIREQ/EUIACK/EUID), buffers fetched 32-bit words as a halfword FIFO, and presents up to two halfwords per cycle to the instruction decoder. Handles branch redirects: flushes the queue, drops any in-flight fetch and restarts at a halfword-aligned target.

Parameters:
DEPTH_HW, 4, queue depth in halfwords; power of 2, >= 4
RESET_PC, 32'hFFFFFFF0, fetch/decode address after reset

Ports:
CLK  input  1  clock
RES  input  1  synchronous active-high reset
CE  input  1  global clock enable; all state advances only when CE=1
EUIA  output  32  fetch address, word aligned ([1:0]=0)
EUIREQ  output  1  fetch request; held until EUIACK
EUIACK  input  1  fetch acknowledge; EUID valid this cycle
EUID  input  32  fetched word
BR_VALID  input  1  redirect strobe (1 cycle)
BR_TARGET  input  32  redirect address; bit 0 ignored
IQ_D  output  32  [15:0]=halfword at IQ_PC, [31:16]=next halfword
IQ_HV  output  2  valid halfwords on IQ_D (0,1,2)
IQ_PC  output  32  address of IQ_D[15:0]
IQ_TAKE  input  2  halfwords consumed this cycle (0..IQ_HV)

Behaviour:
- Reset (RES=1 at CE edge): EUIREQ=0, IQ_HV=0, IQ_PC=RESET_PC, fetch address fa=RESET_PC, count=0, state F_IDLE. RES mid-fetch abandons the fetch; an EUIACK arriving after reset is ignored.
- Storage: DEPTH_HW halfword circular buffer, rptr/wptr wrap modulo DEPTH_HW, count 0..DEPTH_HW. count_next = count - take + added, with added in {0,1,2}; simultaneous take and enqueue are legal, including take at full.
- EUIA = {fa[31:2],2'b00}. EUIREQ = (state==F_REQ)|(state==F_DROP), registered. EUIA is stable while EUIREQ=1.
- FSM:
  F_IDLE: if free=DEPTH_HW-count >= 2 and no BR_VALID -> F_REQ.
  F_REQ: on EUIACK, enqueue the word and set fa=fa+4 (wraps at 2^32). Stay in F_REQ if free after update >= 2 and no BR_VALID, else -> F_IDLE. BR_VALID without EUIACK -> F_DROP.
  F_DROP: keep EUIREQ=1 (the bus cannot cancel). On EUIACK, discard EUID and go to F_REQ at the new fa.
- Enqueue: if fa[1]=0, add 2 halfwords (EUID[15:0] first). If fa[1]=1 (first fetch after a misaligned target), add only EUID[31:16] (1 halfword).
- Redirect (BR_VALID): IQ_TAKE is ignored that cycle. Next cycle: count=0, IQ_HV=0, IQ_PC=fa={BR_TARGET[31:1],1'b0}. If EUIACK occurs in the same cycle, that data is dropped and the FSM goes to F_REQ (or F_IDLE if from F_IDLE). BR_VALID in F_DROP retargets fa; the FSM stays in F_DROP.
- Decoder side: IQ_HV=min(count,2). IQ_D halfwords beyond IQ_HV are don't-care. IQ_PC += 2*IQ_TAKE. Latency: a word acked in cycle N is visible on IQ_HV in N+1.
- IQ_TAKE > IQ_HV is illegal; simulation assertion ($fatal).
- Empty: IQ_HV=0, IQ_TAKE must be 0. Full: no request issued; an in-flight fetch always has room, because the request is only issued with free >= 2 and count can only fall while waiting.

Optional Feature:
IFQ_BYPASS_EN: when defined and count=0 in F_REQ, EUIACK data is forwarded combinationally to IQ_D/IQ_HV in the ack cycle (IQ_HV=2, or 1 if fa[1]=1). Halfwords taken that cycle are not enqueued. Not forwarded when BR_VALID is asserted or in F_DROP. When undefined, IQ_HV reflects stored halfwords only (1-cycle latency).

Test Plan:
- Reset, then ack every request 1 cycle after EUIREQ with EUID=32'h22221111, decoder takes 0 -> EUIA=FFFFFFF0 then FFFFFFF4; FIFO fills to count=4; EUIREQ drops; IQ_D=22221111, IQ_HV=2, IQ_PC=FFFFFFF0.
- Steady state IQ_TAKE=2 every cycle, zero-wait acks -> EUIA increments by 4 with no bubble; IQ_PC advances 4/cycle; count never exceeds DEPTH_HW; no assertion fires.
- BR_VALID with BR_TARGET=32'h00001002 while a fetch is outstanding (no ack) -> F_DROP; next ack discarded; next EUIA=00001000; its data enqueues only the upper halfword; IQ_PC=00001002, IQ_HV=1.
- BR_VALID in the same cycle as EUIACK -> acked data absent from queue; next EUIA=new target; IQ_HV=0 the cycle after.
- fa=FFFFFFFC acked -> next EUIA=00000000 (wrap); rptr/wptr wrap with IQ_TAKE pattern 1,2,1 and data order preserved.
- RES asserted while EUIREQ=1, then EUIACK -> ack ignored; EUIREQ=0 and IQ_HV=0 during reset; restart at FFFFFFF0.
